// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: register enables, bubbles,
// branch/jump squash, memory-wait freeze, halt drain and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DWAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             halt_mem,
  output logic             pc_WEN,
  output logic             ifid_WEN,
  output logic             idex_WEN,
  output logic             exmem_WEN,
  output logic             memwb_WEN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt_out,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WC_W = (DWAIT_MAX < 2) ? 1 : $clog2(DWAIT_MAX + 1);

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            dstall, advance, load_use;
  logic            do_halt, do_branch, do_jump, do_lu;
  logic            stall_evt, flush_evt;

  // Hazard decode and action priority: halt > branch > jump > load-use > normal
  always_comb begin
    dstall    = dmem_req & ~dhit;
    advance   = (state != HALTED) & ihit & ~dstall;
    load_use  = idex_memread & (idex_rt != 5'd0) &
                ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    do_halt   = advance & halt_mem;
    do_branch = advance & ~halt_mem & branch_taken;
    do_jump   = advance & ~halt_mem & ~branch_taken & jump_id;
    do_lu     = advance & ~halt_mem & ~branch_taken & ~jump_id & load_use;
    stall_evt = ((state != HALTED) & ~advance) | do_lu;
    flush_evt = do_branch | do_jump;
  end

  // Register enables and flushes; a flushed register loads a NOP even when enabled
  always_comb begin
    pc_WEN      = 1'b0;
    ifid_WEN    = 1'b0;
    idex_WEN    = 1'b0;
    exmem_WEN   = 1'b0;
    memwb_WEN   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (do_halt) begin
      memwb_WEN = 1'b1;
    end else if (advance) begin
      pc_WEN    = 1'b1;
      ifid_WEN  = 1'b1;
      idex_WEN  = 1'b1;
      exmem_WEN = 1'b1;
      memwb_WEN = 1'b1;
      if (do_branch) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (do_jump) begin
        ifid_flush = 1'b1;
      end else if (do_lu) begin
        pc_WEN     = 1'b0;
        ifid_WEN   = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (do_halt) state_nxt = HALTED;
               else if (dstall) state_nxt = DWAIT;
      DWAIT:   if (do_halt) state_nxt = HALTED;
               else if (!dstall) state_nxt = RUN;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      halt_out    <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (do_halt) halt_out <= 1'b1;
      // Memory-wait watchdog: flags a long wait but never aborts it
      if (state == DWAIT && dstall) begin
        if (32'(wait_cnt) < DWAIT_MAX) wait_cnt <= wait_cnt + WC_W'(1);
        if (32'(wait_cnt) + 32'd1 >= DWAIT_MAX) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (stall_evt && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle expectations are queued by the
// driver and checked by an independent negedge monitor.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DWAIT_MAX = 2;

  // ctl bit order: {pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, memwb_f}
  localparam logic [8:0] NORMAL = 9'b1_1111_0000;
  localparam logic [8:0] FROZEN = 9'b0_0000_0000;
  localparam logic [8:0] RSTV   = 9'b0_0000_1111;
  localparam logic [8:0] HALTV  = 9'b0_0001_0000;
  localparam logic [8:0] BRV    = 9'b1_1111_1110;
  localparam logic [8:0] JMPV   = 9'b1_1111_1000;
  localparam logic [8:0] LUV    = 9'b0_0111_0100;
  localparam logic [8:0] FULL   = 9'b1_1111_1111;
  localparam logic [8:0] BRM    = 9'b1_0001_1111;
  localparam logic [8:0] JMPM   = 9'b1_0111_1111;
  localparam logic [8:0] LUM    = 9'b1_1011_1111;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit = 1'b0, dhit = 1'b0, dmem_req = 1'b0, idex_memread = 1'b0;
  logic [4:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
  logic branch_taken = 1'b0, jump_id = 1'b0, halt_mem = 1'b0;
  logic pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic halt_out, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    logic [8:0]       ctl;
    logic [8:0]       mask;
    logic             halt;
    logic             tmo;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    string            name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DWAIT_MAX(DWAIT_MAX)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .branch_taken(branch_taken), .jump_id(jump_id),
    .halt_mem(halt_mem), .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN),
    .idex_WEN(idex_WEN), .exmem_WEN(exmem_WEN), .memwb_WEN(memwb_WEN),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .halt_out(halt_out), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic push(input logic [8:0] ctl, input logic [8:0] mask, input logic h,
                      input logic t, input int sc, input int fc, input string nm);
    exp_t e;
    e.ctl = ctl; e.mask = mask; e.halt = h; e.tmo = t;
    e.sc = CNT_W'(sc); e.fc = CNT_W'(fc); e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input logic ih, input logic dh, input logic dr, input logic mr,
                      input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rtf,
                      input logic br, input logic jp, input logic hm,
                      input logic [8:0] ctl, input logic [8:0] mask, input logic h,
                      input logic t, input int sc, input int fc, input string nm);
    @(posedge CLK); #1;
    RST = 1'b0;
    ihit = ih; dhit = dh; dmem_req = dr; idex_memread = mr;
    idex_rt = rt; ifid_rs = rs; ifid_rt = rtf;
    branch_taken = br; jump_id = jp; halt_mem = hm;
    push(ctl, mask, h, t, sc, fc, nm);
  endtask

  task automatic norm(input int sc, input int fc, input logic t, input string nm);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NORMAL, FULL, 0, t, sc, fc, nm);
  endtask

  task automatic do_reset(input string nm);
    @(posedge CLK); #1;
    RST = 1'b1;
    ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; idex_memread = 1'b0;
    idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    branch_taken = 1'b0; jump_id = 1'b0; halt_mem = 1'b0;
    push(RSTV, FULL, 0, 0, 0, 0, nm);
  endtask

  // Monitor: every cycle is an output beat; compare it against the oldest expectation
  always @(negedge CLK) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
             ifid_flush, idex_flush, exmem_flush, memwb_flush};
      n_cmp++;
      if ((act & e.mask) !== (e.ctl & e.mask) || halt_out !== e.halt ||
          mem_timeout !== e.tmo || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        n_mis++;
        $display("FAIL %s: got ctl=%b halt=%b tmo=%b stall=%0d flush=%0d, want ctl=%b (mask %b) halt=%b tmo=%b stall=%0d flush=%0d",
                 e.name, act, halt_out, mem_timeout, stall_cnt, flush_cnt,
                 e.ctl, e.mask, e.halt, e.tmo, e.sc, e.fc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset values then free-running pipeline
    do_reset("reset0");
    norm(0, 0, 0, "normal0");
    norm(0, 0, 0, "normal1");

    // 2: load-use on rs, on rt, and suppressed for $zero
    step(1, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0, LUV, LUM, 0, 0, 0, 0, "lu_rs");
    norm(1, 0, 0, "after_lu_rs");
    step(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, NORMAL, FULL, 0, 0, 1, 0, "lu_zero");
    norm(1, 0, 0, "after_lu_zero");
    step(1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, LUV, LUM, 0, 0, 1, 0, "lu_rt");
    norm(2, 0, 0, "after_lu_rt");
    step(1, 0, 0, 0, 5'd7, 5'd7, 5'd7, 0, 0, 0, NORMAL, FULL, 0, 0, 2, 0, "no_memread");

    // 3: branch and jump squash, branch beats load-use and jump
    do_reset("reset1");
    step(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, BRV, BRM, 0, 0, 0, 0, "br_over_lu");
    norm(0, 1, 0, "after_br");
    step(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, JMPV, JMPM, 0, 0, 0, 1, "jmp_over_lu");
    norm(0, 2, 0, "after_jmp");
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, BRV, BRM, 0, 0, 0, 2, "br_over_jmp");
    norm(0, 3, 0, "after_br_jmp");

    // 4: memory wait, timeout after two DWAIT cycles, same-cycle dhit
    do_reset("reset2");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 0, 0, 0, "dwait_c1");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 0, 1, 0, "dwait_c2");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 0, 2, 0, "dwait_c3");
    step(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NORMAL, FULL, 0, 1, 3, 0, "dwait_hit");
    norm(3, 0, 1, "timeout_sticky");
    step(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NORMAL, FULL, 0, 1, 3, 0, "hit_on_entry");
    norm(3, 0, 1, "after_hit_entry");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 1, 3, 0, "rst_mid_dwait_a");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 1, 4, 0, "rst_mid_dwait_b");
    do_reset("reset_in_dwait");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 0, 0, 0, "short_a");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 0, 1, 0, "short_b");
    step(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NORMAL, FULL, 0, 0, 2, 0, "short_hit");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 0, 2, 0, "short2_a");
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 0, 3, 0, "short2_b");
    step(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NORMAL, FULL, 0, 0, 4, 0, "short2_hit");
    norm(4, 0, 0, "wait_cnt_cleared");

    // 5: halt drains MEM/WB only, then everything frozen until reset
    do_reset("reset3");
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, HALTV, FULL, 0, 0, 0, 0, "halt_over_br");
    for (int i = 0; i < 10; i++) begin
      step(logic'(i % 2), 0, 0, 0, 5'd0, 5'd0, 5'd0, logic'((i / 2) % 2), 0, 0,
           FROZEN, FULL, 1, 0, 0, 0, "halted");
    end
    do_reset("reset_halted");
    norm(0, 0, 0, "after_halt_reset");

    // 6: fetch miss stalls saturate the 4-bit counter
    do_reset("reset4");
    for (int i = 0; i < 21; i++) begin
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FROZEN, FULL, 0, 0,
           (i > 15) ? 15 : i, 0, "stall_sat");
    end
    norm(15, 0, 0, "sat_hold");

    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
